// File: rtl/mod_n_down_counter.sv
// Loadable countdown timer: start/abort/enable control, busy and done pulse.
// Define AUTO_RELOAD_EN for periodic mode (reloads the last start value).
module mod_n_down_counter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         en,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         zero_load;

`ifdef AUTO_RELOAD_EN
  logic [N-1:0] reload_q, reload_d;
`endif

  assign zero_load = (load_val == ZERO);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (zero_load) begin
            done_d = 1'b1;
          end else begin
            count_d = load_val;
            state_d = RUN;
`ifdef AUTO_RELOAD_EN
            reload_d = load_val;
`endif
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_d = ZERO;
          state_d = IDLE;
        end else if (start) begin
          if (zero_load) begin
            count_d = ZERO;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = load_val;
`ifdef AUTO_RELOAD_EN
            reload_d = load_val;
`endif
          end
        end else if (en) begin
          if (count_q == ONE) begin
            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = ZERO;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reload_q <= ZERO;
    else     reload_q <= reload_d;
  end
`endif

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Bench for mod_n_down_counter: directed steps plus random traffic
// against an integer-level model of the countdown rules.
module tb_mod_n_down_counter;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] load_val;
  logic         start;
  logic         en;
  logic         abort;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  // model: remaining cycles, running flag, pulse, period
  bit m_run;
  bit m_done;
  int m_cnt;
  int m_per;

  mod_n_down_counter #(.N(N)) dut (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start),
    .en(en), .abort(abort), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_cnt = 0; m_per = 0;
  endtask

  task automatic model_step(bit s, bit a, bit e, int lv);
    m_done = 0;
    if (!m_run) begin
      if (s) begin
        if (lv != 0) begin
          m_cnt = lv; m_per = lv; m_run = 1;
        end else m_done = 1;
      end
    end else if (a) begin
      m_cnt = 0; m_run = 0;
    end else if (s) begin
      if (lv != 0) begin
        m_cnt = lv; m_per = lv;
      end else begin
        m_cnt = 0; m_done = 1; m_run = 0;
      end
    end else if (e) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1;
`ifdef AUTO_RELOAD_EN
        m_cnt = m_per;
`else
        m_run = 0;
`endif
      end
    end
  endtask

  task automatic cyc(bit s, bit a, bit e, int lv);
    start = s; abort = a; en = e;
    load_val = lv[N-1:0];
    @(posedge clk);
    model_step(s, a, e, lv);
    #1;
    chk("count", count, m_cnt);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
  endtask

  task automatic latency(int lv, int budget, string tag);
    int n;
    cyc(1, 0, 1, lv);
    n = 0;
    while (!done && n < budget) begin
      cyc(0, 0, 1, 0);
      n++;
    end
    chk(tag, n, lv);
    cyc(0, 1, 0, 0);
  endtask

  initial begin
    int dones;
    rst = 1; start = 0; en = 0; abort = 0; load_val = '0;
    model_reset();
    #20;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 0;

    latency(5, 50, "lat5");

    // enable gating: hold at 2 for three cycles
    cyc(1, 0, 1, 4);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("gate_two", count, 2);
    repeat (3) cyc(0, 0, 0, 0);
    chk("gate_hold", count, 2);
    cyc(0, 0, 1, 0);
    chk("gate_pre", done, 0);
    cyc(0, 0, 1, 0);
    chk("gate_done7", done, 1);
    cyc(0, 1, 0, 0);

    // abort at 6
    cyc(1, 0, 1, 10);
    repeat (4) cyc(0, 0, 1, 0);
    chk("abort_at6", count, 6);
    cyc(0, 1, 1, 0);
    chk("abort_cnt", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);

    // retrigger at 6 with 3
    cyc(1, 0, 1, 10);
    repeat (4) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 3);
    chk("retrig_cnt", count, 3);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("retrig_done", done, 1);
    cyc(0, 1, 0, 0);

    // abort and start together
    cyc(1, 0, 1, 10);
    cyc(1, 1, 1, 7);
    chk("abort_wins", count, 0);
    chk("abort_wins_busy", busy, 0);

    // zero-length countdown
    cyc(1, 0, 1, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    cyc(0, 0, 1, 0);
    chk("zero_pulse", done, 0);

    latency(1, 10, "lat1");
    latency(1023, 1100, "lat1023");

    // periodic behaviour over 12 enabled cycles
    cyc(1, 0, 1, 3);
    dones = 0;
    repeat (12) begin
      cyc(0, 0, 1, 0);
      if (done) dones++;
    end
`ifdef AUTO_RELOAD_EN
    chk("periods", dones, 4);
`else
    chk("periods", dones, 1);
`endif
    cyc(0, 1, 0, 0);
    chk("per_abort_cnt", count, 0);
    chk("per_abort_busy", busy, 0);

    // async reset between edges
    cyc(1, 0, 1, 10);
    repeat (6) cyc(0, 0, 1, 0);
    chk("pre_rst", count, 4);
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 0;

    repeat (400) begin
      bit s, a, e;
      int lv;
      s = ($urandom % 8) == 0;
      a = ($urandom % 16) == 0;
      e = ($urandom % 4) != 0;
      lv = (($urandom % 4) == 0) ? int'($urandom % 1024) : int'($urandom % 8);
      cyc(s, a, e, lv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
